// File: rtl/key_pkg.sv
// Shared definitions for the push-button priority encoder.
//   deb_state_t      : debounce FSM states (STABLE, COUNT)
//   KEY_RELEASED     : raw/debounced vector with no key pressed (active-low)
//   LED_OFF          : all active-low LEDs dark
//   DEBOUNCE_DEFAULT : 20 ms at 50 MHz
//   prio_code()      : lowest pressed index of an active-low key vector
package key_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } deb_state_t;

    localparam logic [3:0] KEY_RELEASED     = 4'b1111;
    localparam logic [3:0] LED_OFF          = 4'b1111;
    localparam int         DEBOUNCE_DEFAULT = 1000000;

    // key0 has the highest priority; an all-released vector returns 0
    // and the caller is expected to qualify it with the valid flag.
    function automatic logic [1:0] prio_code(input logic [3:0] keys);
        logic [1:0] code;
        code = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!keys[i]) code = 2'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus vector debouncer for four active-low keys.
// A changed vector is accepted once it has been seen unchanged for
// DEBOUNCE_CYCLES consecutive cycles after the first differing sample.
//   clk, rst_n : clock, asynchronous active-low reset
//   key        : raw active-low buttons, asynchronous to clk
//   stable     : accepted key vector, including a value being accepted
//                on the coming edge (so consumers can register in step)
//   upd        : high in the cycle whose edge loads a new accepted vector
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key,
    output logic [3:0] stable,
    output logic       upd
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1, sync2;
    logic [3:0]       stable_q, stable_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    deb_state_t       state_q, state_d;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= KEY_RELEASED;
            sync2    <= KEY_RELEASED;
            stable_q <= KEY_RELEASED;
            cand_q   <= KEY_RELEASED;
            cnt_q    <= '0;
            state_q  <= STABLE;
        end else begin
            sync1    <= key;
            sync2    <= sync1;
            stable_q <= stable_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    // NOTE: every signal gets a hold default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        upd      = 1'b0;
        case (state_q)
            STABLE: begin
                if (sync2 != stable_q) begin
                    state_d = COUNT;
                    cand_d  = sync2;
                    cnt_d   = '0;
                end
            end
            COUNT: begin
                if (sync2 == stable_q) begin
                    // Bounced back before acceptance: drop the candidate.
                    state_d = STABLE;
                end else if (sync2 != cand_q) begin
                    cand_d = sync2;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Leaving COUNT here is what keeps the counter from wrapping.
                    stable_d = cand_q;
                    upd      = 1'b1;
                    state_d  = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = STABLE;
        endcase
    end

    assign stable = stable_d;

endmodule

// File: rtl/key_prio_encoder.sv
// Debounced priority encoder for the kit's four active-low push-buttons.
//   CLK, RST_N : clock, asynchronous active-low reset
//   KEY        : raw active-low buttons
//   CODE       : index of the lowest pressed key (held while none pressed)
//   VALID      : at least one debounced key pressed
//   PRESS      : one-cycle strobe on a new press or a change of CODE
//   LED        : active-low mirror {~VALID, off, ~CODE}
module key_prio_encoder
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] KEY,
    output logic [1:0] CODE,
    output logic       VALID,
    output logic       PRESS,
    output logic [3:0] LED
);

    logic [3:0] stable;
    logic       upd;
    logic       valid_nxt;
    logic [1:0] code_nxt;
    logic       press_nxt;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (CLK),
        .rst_n (RST_N),
        .key   (KEY),
        .stable(stable),
        .upd   (upd)
    );

    // Encode the vector being accepted so outputs update on the same edge
    // as the debounced register rather than one cycle later.
    always_comb begin
        valid_nxt = VALID;
        code_nxt  = CODE;
        press_nxt = 1'b0;
        if (upd) begin
            valid_nxt = ~&stable;
            if (valid_nxt) code_nxt = prio_code(stable);
            // Releasing to none, or adding a lower-priority key, is silent.
            press_nxt = valid_nxt && (!VALID || code_nxt != CODE);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CODE  <= 2'b00;
            VALID <= 1'b0;
            PRESS <= 1'b0;
            LED   <= LED_OFF;
        end else begin
            CODE  <= code_nxt;
            VALID <= valid_nxt;
            PRESS <= press_nxt;
            LED   <= {~valid_nxt, 1'b1, ~code_nxt};
        end
    end

endmodule
